// File: rtl/state_sequencer.sv
// ============================================================================
// Module   : state_sequencer
// Purpose  : Instruction-cycle sequencer for a small CPU. Steps through
//            FETCH -> EXEC1 -> EXEC2 and holds the current state while the
//            memory bus asserts waitrequest. A halting instruction in EXEC2
//            parks the sequencer in HALTED. A stall that runs too long also
//            parks it in HALTED and raises a sticky bus error. Retired
//            instructions are counted in a free-running wrapping counter.
// Ports    : clk              - system clock, rising-edge active
//            reset            - synchronous active-high reset
//            waitrequest_i    - memory not ready, hold the bus transaction
//            mem_access_i     - EXEC1/EXEC2 cycle touches memory
//            halt_req_i       - EXEC2 instruction jumps to address 0
//            fetch_o          - FETCH-state strobe
//            exec_one_o       - EXEC1-state strobe
//            exec_two_o       - EXEC2-state strobe
//            state_o          - encoded state (0 FETCH, 1 EXEC1, 2 EXEC2, 3 HALTED)
//            ir_load_o        - load instruction register this cycle
//            pc_update_o      - commit next PC this cycle
//            stall_o          - state is held this cycle
//            active_o         - CPU running (not HALTED)
//            bus_error_o      - sticky stall-timeout flag
//            retired_count_o  - completed instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_sequencer #(
    parameter int COUNT_W   = 32,
    parameter int MAX_STALL = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest_i,
    input  logic               mem_access_i,
    input  logic               halt_req_i,
    output logic               fetch_o,
    output logic               exec_one_o,
    output logic               exec_two_o,
    output logic [1:0]         state_o,
    output logic               ir_load_o,
    output logic               pc_update_o,
    output logic               stall_o,
    output logic               active_o,
    output logic               bus_error_o,
    output logic [COUNT_W-1:0] retired_count_o
);

    // Wide enough to hold MAX_STALL itself; never narrower than one bit.
    localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC1  = 2'd1,
        ST_EXEC2  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [COUNT_W-1:0]   retired_q,   retired_d;
    logic                 bus_err_q,   bus_err_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            stall_cnt_q <= '0;
            retired_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            retired_q   <= retired_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and cycle outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = '0;
        retired_d   = retired_q;
        bus_err_d   = bus_err_q;
        ir_load_o   = 1'b0;
        pc_update_o = 1'b0;
        stall_o     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Instruction fetch always uses the bus, so only waitrequest matters.
                if (waitrequest_i) begin
                    stall_o = 1'b1;
                end else begin
                    ir_load_o = 1'b1;
                    state_d   = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                if (mem_access_i && waitrequest_i) begin
                    stall_o = 1'b1;
                end else begin
                    state_d = ST_EXEC2;
                end
            end
            ST_EXEC2: begin
                // A halt request only takes effect once the instruction retires.
                if (mem_access_i && waitrequest_i) begin
                    stall_o = 1'b1;
                end else begin
                    pc_update_o = 1'b1;
                    retired_d   = retired_q + 1'b1;
                    state_d     = halt_req_i ? ST_HALTED : ST_FETCH;
                end
            end
            default: begin
                // HALTED: frozen until reset, all inputs ignored.
            end
        endcase

        // Stall watchdog: the cycle that finds the counter already at the
        // limit is the last one tolerated; the sequencer then parks.
        if (stall_o) begin
            if (stall_cnt_q == STALL_W'(MAX_STALL)) begin
                state_d   = ST_HALTED;
                bus_err_d = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State decodes and registered outputs
    // ------------------------------------------------------------------
    assign fetch_o         = (state_q == ST_FETCH);
    assign exec_one_o      = (state_q == ST_EXEC1);
    assign exec_two_o      = (state_q == ST_EXEC2);
    assign active_o        = (state_q != ST_HALTED);
    assign state_o         = state_q;
    assign bus_error_o     = bus_err_q;
    assign retired_count_o = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_state_sequencer.sv
`default_nettype none

module tb_state_sequencer;

    localparam int CW = 4;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          waitrequest_i;
    logic          mem_access_i;
    logic          halt_req_i;
    logic          fetch_o;
    logic          exec_one_o;
    logic          exec_two_o;
    logic [1:0]    state_o;
    logic          ir_load_o;
    logic          pc_update_o;
    logic          stall_o;
    logic          active_o;
    logic          bus_error_o;
    logic [CW-1:0] retired_count_o;

    int vectors     = 0;
    int miscompares = 0;

    state_sequencer #(
        .COUNT_W   (CW),
        .MAX_STALL (MS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .waitrequest_i   (waitrequest_i),
        .mem_access_i    (mem_access_i),
        .halt_req_i      (halt_req_i),
        .fetch_o         (fetch_o),
        .exec_one_o      (exec_one_o),
        .exec_two_o      (exec_two_o),
        .state_o         (state_o),
        .ir_load_o       (ir_load_o),
        .pc_update_o     (pc_update_o),
        .stall_o         (stall_o),
        .active_o        (active_o),
        .bus_error_o     (bus_error_o),
        .retired_count_o (retired_count_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs and let combinational outputs settle before sampling.
    task automatic set_in(input logic w, input logic m, input logic h);
        waitrequest_i = w;
        mem_access_i  = m;
        halt_req_i    = h;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        #1;
        vectors++;
        if ({state_o, fetch_o, exec_one_o, exec_two_o, active_o, bus_error_o} !== 7'b00_100_10
            || retired_count_o !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: state=%0d f/e1/e2=%b%b%b active=%b err=%b cnt=%0d, want state=0 f/e1/e2=100 active=1 err=0 cnt=0",
                     state_o, fetch_o, exec_one_o, exec_two_o, active_o, bus_error_o, retired_count_o);
        end
        vectors++;
        if ({stall_o, ir_load_o, pc_update_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_comb: stall/ir/pc=%b%b%b, want 100 (FETCH rules with waitrequest=1)",
                     stall_o, ir_load_o, pc_update_o);
        end
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_nominal();
        int exp_st[6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b0, 1'b0);
            vectors++;
            if (state_o !== 2'(exp_st[i]) || ir_load_o !== (i % 3 == 0)
                || pc_update_o !== (i % 3 == 2) || stall_o !== 1'b0
                || fetch_o !== (exp_st[i] == 0) || exec_one_o !== (exp_st[i] == 1)
                || exec_two_o !== (exp_st[i] == 2)) begin
                miscompares++;
                $display("FAIL nominal_cycle%0d: state=%0d ir=%b pc=%b stall=%b f/e1/e2=%b%b%b, want state=%0d ir=%b pc=%b stall=0",
                         i + 1, state_o, ir_load_o, pc_update_o, stall_o, fetch_o, exec_one_o,
                         exec_two_o, exp_st[i], (i % 3 == 0), (i % 3 == 2));
            end
            tick();
        end
        vectors++;
        if (retired_count_o !== 4'd2) begin
            miscompares++;
            $display("FAIL nominal_count: got %0d, want 2", retired_count_o);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stalls();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(i < 3, 1'b0, 1'b0);
            vectors++;
            if (state_o !== 2'd0 || stall_o !== (i < 3) || ir_load_o !== (i == 3)) begin
                miscompares++;
                $display("FAIL fetch_stall%0d: state=%0d stall=%b ir=%b, want state=0 stall=%b ir=%b",
                         i, state_o, stall_o, ir_load_o, (i < 3), (i == 3));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(i < 2, 1'b1, 1'b0);
            vectors++;
            if (state_o !== 2'd1 || stall_o !== (i < 2)) begin
                miscompares++;
                $display("FAIL exec1_stall%0d: state=%0d stall=%b, want state=1 stall=%b",
                         i, state_o, stall_o, (i < 2));
            end
            tick();
        end
        #1;
        vectors++;
        if (state_o !== 2'd2) begin
            miscompares++;
            $display("FAIL exec1_exit: state=%0d, want 2", state_o);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt();
        do_reset();
        set_in(1'b0, 1'b0, 1'b1);   // halt_req ignored in FETCH
        tick();
        set_in(1'b0, 1'b0, 1'b1);   // and in EXEC1
        tick();
        set_in(1'b0, 1'b0, 1'b1);
        vectors++;
        if (state_o !== 2'd2 || pc_update_o !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_exec2: state=%0d pc=%b, want state=2 pc=1", state_o, pc_update_o);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if (state_o !== 2'd3 || active_o !== 1'b0 || retired_count_o !== 4'd1
                || {fetch_o, exec_one_o, exec_two_o, ir_load_o, pc_update_o, stall_o} !== 6'b0
                || bus_error_o !== 1'b0) begin
                miscompares++;
                $display("FAIL halted_hold%0d: state=%0d active=%b cnt=%0d strobes=%b%b%b%b%b%b err=%b, want state=3 active=0 cnt=1 strobes=0 err=0",
                         i, state_o, active_o, retired_count_o, fetch_o, exec_one_o, exec_two_o,
                         ir_load_o, pc_update_o, stall_o, bus_error_o);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < MS + 1; i++) begin
            set_in(1'b1, 1'b0, 1'b0);
            vectors++;
            if (state_o !== 2'd0 || stall_o !== 1'b1 || bus_error_o !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_stall%0d: state=%0d stall=%b err=%b, want state=0 stall=1 err=0",
                         i, state_o, stall_o, bus_error_o);
            end
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0);
        vectors++;
        if (state_o !== 2'd3 || bus_error_o !== 1'b1 || active_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_fire: state=%0d err=%b active=%b stall=%b, want state=3 err=1 active=0 stall=0",
                     state_o, bus_error_o, active_o, stall_o);
        end
        reset = 1'b1;
        tick();
        #1;
        vectors++;
        if (state_o !== 2'd0 || bus_error_o !== 1'b0 || retired_count_o !== '0 || active_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_reset: state=%0d err=%b cnt=%0d active=%b, want 0/0/0/1",
                     state_o, bus_error_o, retired_count_o, active_o);
        end
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            for (int c = 0; c < 3; c++) begin
                set_in(1'b0, 1'($urandom), 1'b0);
                tick();
            end
            vectors++;
            if (retired_count_o !== 4'(k % 16)) begin
                miscompares++;
                $display("FAIL wrap_after%0d: got %0d, want %0d", k, retired_count_o, k % 16);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_in_stall();
        do_reset();
        for (int c = 0; c < 5; c++) begin   // one full instruction, then FETCH, EXEC1
            set_in(1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        vectors++;
        if (state_o !== 2'd2 || stall_o !== 1'b1 || pc_update_o !== 1'b0 || retired_count_o !== 4'd1) begin
            miscompares++;
            $display("FAIL rst_stall_pre: state=%0d stall=%b pc=%b cnt=%0d, want 2/1/0/1",
                     state_o, stall_o, pc_update_o, retired_count_o);
        end
        tick();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        vectors++;
        if (state_o !== 2'd0 || active_o !== 1'b1 || pc_update_o !== 1'b0
            || ir_load_o !== 1'b1 || retired_count_o !== '0) begin
            miscompares++;
            $display("FAIL rst_stall_post: state=%0d active=%b pc=%b ir=%b cnt=%0d, want 0/1/0/1/0",
                     state_o, active_o, pc_update_o, ir_load_o, retired_count_o);
        end
        tick();
        vectors++;
        if (state_o !== 2'd1) begin
            miscompares++;
            $display("FAIL rst_stall_resume: state=%0d, want 1", state_o);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase index of the instruction cycle, a run length of
    // consecutive held cycles, an instruction tally and an error latch.
    task automatic test_random();
        int   phase   = 0;
        int   run     = 0;
        int   tally   = 0;
        bit   err     = 0;
        bit   w, m, h, r, held;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            w = ($urandom_range(0, 3) == 0);
            m = 1'($urandom);
            h = ($urandom_range(0, 7) == 0);
            r = (phase == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            reset = r;
            set_in(w, m, h);

            if (phase == 3)      held = 0;
            else if (phase == 0) held = w;
            else                 held = m && w;

            vectors++;
            if (state_o !== 2'(phase) || stall_o !== held
                || ir_load_o !== (phase == 0 && !w) || pc_update_o !== (phase == 2 && !held)
                || active_o !== (phase != 3) || bus_error_o !== err
                || retired_count_o !== 4'(tally % 16)
                || {fetch_o, exec_one_o, exec_two_o} !== {phase == 0, phase == 1, phase == 2}) begin
                miscompares++;
                $display("FAIL random_%0d: state=%0d stall=%b ir=%b pc=%b act=%b err=%b cnt=%0d, want state=%0d stall=%b ir=%b pc=%b act=%b err=%b cnt=%0d",
                         n, state_o, stall_o, ir_load_o, pc_update_o, active_o, bus_error_o,
                         retired_count_o, phase, held, (phase == 0 && !w), (phase == 2 && !held),
                         (phase != 3), err, tally % 16);
            end
            tick();

            if (r) begin
                phase = 0; run = 0; tally = 0; err = 0;
            end else if (phase != 3) begin
                if (held) begin
                    if (run == MS) begin
                        phase = 3; err = 1; run = 0;
                    end else begin
                        run++;
                    end
                end else begin
                    run = 0;
                    if (phase == 2) begin
                        tally++;
                        phase = h ? 3 : 0;
                    end else begin
                        phase++;
                    end
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        waitrequest_i = 1'b0;
        mem_access_i  = 1'b0;
        halt_req_i    = 1'b0;
        test_reset();
        test_nominal();
        test_stalls();
        test_halt();
        test_timeout();
        test_wrap();
        test_reset_in_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 Parameter COUNT_W, default 32, SHALL set the width of retired_count.
REQ-002 Parameter MAX_STALL, default 255, SHALL set the maximum consecutive stall cycles tolerated before a bus error.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 waitrequest  input  1  memory not ready; the current bus transaction must be held.
REQ-006 mem_access  input  1  the current EXEC1/EXEC2 cycle issues a memory read or write (ignored in FETCH).
REQ-007 halt_req  input  1  the instruction in EXEC2 jumps to address 0; the CPU must stop after it completes.
REQ-008 fetch  output  1  FETCH-state strobe to the decoder.
REQ-009 exec_one  output  1  EXEC1-state strobe.
REQ-010 exec_two  output  1  EXEC2-state strobe.
REQ-011 state  output  2  encoded state: FETCH=0, EXEC1=1, EXEC2=2, HALTED=3.
REQ-012 ir_load  output  1  loads the instruction register this cycle.
REQ-013 pc_update  output  1  commits the next PC this cycle.
REQ-014 stall  output  1  the state is held this cycle.
REQ-015 active  output  1  the CPU is running (not HALTED).
REQ-016 bus_error  output  1  sticky flag indicating the stall timeout fired.
REQ-017 retired_count  output  COUNT_W  number of completed instructions.

Function
REQ-018 fetch, exec_one and exec_two SHALL be combinational decodes of state, at most one high at a time, and all low in HALTED.
REQ-019 FETCH behaviour:
- waitrequest=1 -> stall=1, remain in FETCH.
- waitrequest=0 -> ir_load=1, next state EXEC1.
REQ-020 EXEC1 behaviour:
- mem_access=1 and waitrequest=1 -> stall=1, remain in EXEC1.
- otherwise -> next state EXEC2.
REQ-021 EXEC2 behaviour:
- mem_access=1 and waitrequest=1 -> stall=1, remain in EXEC2; halt_req is not acted on.
- otherwise -> pc_update=1 and retired_count increments.
- Next state is HALTED if halt_req=1, else FETCH.
REQ-022 HALTED SHALL hold until reset: active=0, every strobe low, the counter frozen, and all inputs ignored.
REQ-023 halt_req SHALL be ignored in every state except EXEC2.
REQ-024 ir_load, pc_update and stall SHALL be combinational from state and inputs, and SHALL be low in HALTED.
REQ-025 A stall counter (width ceil(log2(MAX_STALL+1))) SHALL increment on each stall=1 cycle and clear to 0 on any non-stall cycle.
REQ-026 Stall timeout: on a stall cycle where the stall counter already equals MAX_STALL, the next state SHALL be HALTED and bus_error SHALL set.
- bus_error stays set until reset.
- retired_count does not increment.
REQ-027 retired_count SHALL wrap from 2^COUNT_W-1 to 0 without any flag.
REQ-028 Minimum latency SHALL be 3 cycles per instruction (FETCH, EXEC1, EXEC2); each stall cycle adds exactly one cycle in the stalled state.

Reset
REQ-029 reset=1 at a clock edge SHALL force, on the next cycle, all of the following:
- state=FETCH, active=1, bus_error=0.
- retired_count=0, stall counter=0.
REQ-030 Reset SHALL take priority over every input and every state, including HALTED and any in-progress stall.
REQ-031 While reset=1, registered outputs SHALL hold their reset values; fetch=1, and the combinational outputs follow the FETCH rules.

Verification
REQ-032 Reset release, waitrequest=0, mem_access=0, halt_req=0 for 6 cycles -> state sequence 0,1,2,0,1,2; ir_load high in cycles 1 and 4; pc_update high in cycles 3 and 6; retired_count=2.
REQ-033 waitrequest=1 for 3 cycles in FETCH -> stall=1 for 3 cycles, state stays 0, ir_load only on the 4th cycle; in EXEC1, mem_access=1 with waitrequest=1 for 2 cycles -> EXEC1 lasts 3 cycles.
REQ-034 halt_req=1 in EXEC2 with no stall -> pc_update=1 and retired_count increments; next state=3, active=0; further inputs cause no change for 10 cycles.
REQ-035 MAX_STALL=4, waitrequest held 1 in FETCH -> 5 stall cycles, then state=3 and bus_error=1; assert reset -> state=0, bus_error=0, retired_count=0.
REQ-036 COUNT_W=4, run 17 instructions -> retired_count reads 15 after the 15th instruction, 0 after the 16th, 1 after the 17th.
REQ-037 Reset asserted in EXEC2 during a stall, together with halt_req=1 -> next cycle state=0, active=1, no pc_update; normal fetch resumes.
